alu_div: RTL and testbench
==========================

Name: alu_div

Overview:
- Iterative RV32M divider/remainder unit for the execute stage.
- Consumes the same 6-bit alucode and op1/op2 operands that decode supplies to the combinational multiplier; covers DIV/DIVU/REM/REMU, which are too costly to do combinationally.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Start/busy/done handshake; the pipeline controller stalls on busy and captures the result on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while busy=0
- kill  input  1  flush; aborts any in-flight operation
- alucode  input  6  operation select: `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU (define.vh)
- op1  input  32  dividend
- op2  input  32  divisor
- busy  output  1  operation in flight; upstream must stall
- done  output  1  one-cycle pulse; result valid this cycle
- alu_result  output  32  quotient or remainder; held until the next accepted start

Behaviour:
- One clock; reset is synchronous and active-high. rst=1 at an edge forces IDLE, busy=0, done=0, alu_result=0, and clears all internal registers, including mid-operation.
- States:
  - IDLE: not busy.
  - CALC: 32 iterations.
  - DONE: one cycle with done=1.
- Accept: at edge E0, state IDLE or DONE, start=1, kill=0, and alucode is one of the four div codes. Any other alucode leaves the unit in IDLE with outputs unchanged.
- Operands and op kind are latched at accept; later changes on op1/op2/alucode are ignored.
- start while busy=1 is ignored; no queueing.
- Signed ops (DIV/REM):
  - Operate on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Negation applied in the DONE transition.
- Normal path:
  - E0 loads remainder=0, quotient=|dividend|, counter=31.
  - Edges E1..E32 each shift {rem,quot} left 1, trial-subtract the divisor, and keep the difference plus set the quotient LSB if it is non-negative.
  - E33 registers the signed-corrected result into alu_result and enters DONE.
  - done=1 for exactly the cycle after E33. busy=1 from after E0 through after E32, and busy=0 while done=1.
- Fast path, decided at E0, result registered at E1 with done=1 the cycle after E1:
  - Divide by zero (op2=0): DIV/DIVU gives 0xFFFFFFFF; REM/REMU gives op1.
  - Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- A start in the DONE cycle is accepted, giving back-to-back operation; the done pulse is still emitted.
- kill=1 at any edge returns the unit to IDLE with done=0 and alu_result unchanged.
  - If kill and start are both asserted at an IDLE edge, kill wins and nothing is accepted.
  - kill coincident with the E33 edge suppresses done.
- Arithmetic uses a 33-bit trial subtract, so there is no overflow for unsigned divisors ≥ 0x80000000.

Test Plan:
- DIV 100/7 and REM 100/7 -> alu_result=14, then 2. done exactly 34 cycles after the accepting edge. busy high for 33 cycles.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REMU 7/0xFFFFFFFE -> 7. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Division by zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done 2 cycles after accept. Overflow: DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Second start at cycle 10 of a running DIV with different operands -> ignored; the first result (100/7=14) is returned on schedule.
- kill at cycle 20 of an operation -> busy falls next cycle and no done occurs. rst asserted mid-CALC -> all outputs 0 next cycle.
- start held high in the DONE cycle with new operands (DIVU 81/9) -> first done pulse seen, then a second done with 9 after a further 34 cycles.

Source files
------------

// File: rtl/alu_div.sv
// alu_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, start/busy/done handshake, kill flush.
module alu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [5:0]      alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] alu_result
);
  localparam logic [5:0] ALU_DIV = 6'd24, ALU_DIVU = 6'd25, ALU_REM = 6'd26, ALU_REMU = 6'd27;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] rem, quot, dvs, a_abs, b_abs, fast_val, res, fin;
  logic [XLEN:0] sh, diff;
  logic [5:0] cnt;
  logic is_rem, neg, sgn, opr, valid, accept, fast, ge;
  always_comb begin
    sgn = alucode == ALU_DIV || alucode == ALU_REM;
    opr = alucode == ALU_REM || alucode == ALU_REMU;
    valid = sgn || alucode == ALU_DIVU || alucode == ALU_REMU;
    accept = state != CALC && start && !kill && valid;
    a_abs = sgn && op1[XLEN-1] ? -op1 : op1;
    b_abs = sgn && op2[XLEN-1] ? -op2 : op2;
    fast = op2 == '0 || (sgn && op1 == {1'b1, {(XLEN-1){1'b0}}} && &op2);
    fast_val = op2 == '0 ? (opr ? op1 : '1) : (opr ? '0 : op1);
    sh = {rem, quot[XLEN-1]};
    diff = sh - {1'b0, dvs};
    // a set top bit of the shifted remainder already exceeds any divisor
    ge = sh[XLEN] | ~diff[XLEN];
    res = is_rem ? rem : quot;
    fin = neg ? -res : res;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    if (kill) state_n = IDLE;
    else if (accept) state_n = CALC;
    else if (state == CALC) state_n = cnt[5] ? DONE : CALC;
  end
  always_comb begin
    busy = state == CALC;
    done = state == DONE;
  end
  // cnt counts 31..0 through the iterations, then wraps to 63 to mark the result step
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      cnt <= '0;
      is_rem <= 1'b0;
      neg <= 1'b0;
      alu_result <= '0;
    end else if (!kill) begin
      if (accept) begin
        rem <= '0;
        quot <= fast ? fast_val : a_abs;
        dvs <= b_abs;
        cnt <= fast ? 6'h3f : 6'(XLEN-1);
        is_rem <= !fast && opr;
        neg <= !fast && sgn && (opr ? op1[XLEN-1] : op1[XLEN-1] ^ op2[XLEN-1]);
      end else if (state == CALC) begin
        if (cnt[5]) alu_result <= fin;
        else begin
          rem <= ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
          quot <= {quot[XLEN-2:0], ge};
          cnt <= cnt - 6'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: randomized and directed checks of alu_div against an arithmetic reference model.
module tb_alu_div;
  localparam logic [5:0] C_DIV = 6'd24, C_DIVU = 6'd25, C_REM = 6'd26, C_REMU = 6'd27;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [5:0] alucode = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic busy, done;
  logic [31:0] alu_result;
  int total = 0, passed = 0;

  alu_div dut (.clk(clk), .rst(rst), .start(start), .kill(kill), .alucode(alucode),
               .op1(op1), .op2(op2), .busy(busy), .done(done), .alu_result(alu_result));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return (c == C_DIV || c == C_DIVU) ? 32'hFFFF_FFFF : a;
    if ((c == C_DIV || c == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return c == C_DIV ? a : 32'h0;
    case (c)
      C_DIV:   return sa / sb;
      C_REM:   return sa % sb;
      C_DIVU:  return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || ((c == C_DIV || c == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  // k counts cycles after the accepting edge; outputs sampled on the falling edge
  task automatic run(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input bit b2b,
                     input int poke_at, input int kill_at,
                     output logic [31:0] r, output int dk, output int bc, output logic busy_ak);
    if (!b2b) @(negedge clk);
    start = 1'b1; alucode = c; op1 = a; op2 = b;
    @(negedge clk);
    dk = 0; bc = 0; r = 'x; busy_ak = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (k == kill_at + 1) busy_ak = busy;
      if (busy) bc++;
      if (done) begin
        dk = k;
        r = alu_result;
        break;
      end
      start = (k == poke_at);
      kill = (k == kill_at);
      alucode = (k == poke_at) ? C_DIVU : 6'($urandom);
      op1 = (k == poke_at) ? 32'd81 : $urandom;
      op2 = (k == poke_at) ? 32'd9 : $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    kill = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (alu_result !== 32'h0) $display("FAIL reset_result got %h exp 0", alu_result); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [5:0] cs[10] = '{C_DIV, C_REM, C_DIV, C_REM, C_REMU, C_DIVU, C_DIVU, C_REM, C_DIV, C_REM};
    logic [31:0] as[10] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7, 32'hFFFF_FFFF, 5, 5,
                            32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[10] = '{7, 7, 2, 2, 32'hFFFF_FFFE, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es[10] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5,
                            32'h8000_0000, 0};
    int ls[10] = '{34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    logic [31:0] r;
    int dk, bc;
    logic bak;
    for (int i = 0; i < 10; i++) begin
      run(cs[i], as[i], bs[i], 0, 99, 99, r, dk, bc, bak);
      total++; if (r !== es[i]) $display("FAIL directed_%0d_result got %h exp %h", i, r, es[i]); else passed++;
      total++; if (dk !== ls[i]) $display("FAIL directed_%0d_latency got %0d exp %0d", i, dk, ls[i]); else passed++;
      total++; if (bc !== ls[i] - 1) $display("FAIL directed_%0d_busy_cycles got %0d exp %0d", i, bc, ls[i] - 1); else passed++;
    end
  endtask

  task automatic test_random;
    logic [5:0] codes[4] = '{C_DIV, C_DIVU, C_REM, C_REMU};
    logic [5:0] c;
    logic [31:0] a, b, r;
    int dk, bc, sel;
    logic bak;
    for (int i = 0; i < 48; i++) begin
      c = codes[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = b | 32'h8000_0000;
      run(c, a, b, 0, 99, 99, r, dk, bc, bak);
      total++; if (r !== model(c, a, b)) $display("FAIL random_%0d_result code %0d a %h b %h got %h exp %h", i, c, a, b, r, model(c, a, b)); else passed++;
      total++; if (dk !== model_lat(c, a, b)) $display("FAIL random_%0d_latency got %0d exp %0d", i, dk, model_lat(c, a, b)); else passed++;
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] r;
    int dk, bc;
    logic bak;
    run(C_DIV, 100, 7, 0, 10, 99, r, dk, bc, bak);
    total++; if (r !== 32'd14) $display("FAIL ignore_start_result got %h exp %h", r, 32'd14); else passed++;
    total++; if (dk !== 34) $display("FAIL ignore_start_latency got %0d exp 34", dk); else passed++;
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    start = 1'b1; alucode = C_DIVU; op1 = 32'd1000; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done got %b exp 0", done); else passed++;
    total++; if (alu_result !== 32'h0) $display("FAIL rst_mid_result got %h exp 0", alu_result); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_kill;
    logic [31:0] r, prev;
    int dk, bc;
    logic bak;
    run(C_DIVU, 32'd77, 32'd5, 0, 99, 99, r, dk, bc, bak);
    prev = 32'd15;
    total++; if (r !== prev) $display("FAIL kill_setup_result got %h exp %h", r, prev); else passed++;
    run(C_DIVU, 32'd1000, 32'd3, 0, 99, 20, r, dk, bc, bak);
    total++; if (bak !== 1'b0) $display("FAIL kill20_busy got %b exp 0", bak); else passed++;
    total++; if (dk !== 0) $display("FAIL kill20_done got cycle %0d exp none", dk); else passed++;
    total++; if (alu_result !== prev) $display("FAIL kill20_result got %h exp %h", alu_result, prev); else passed++;
    run(C_REM, 32'hFFFF_FF00, 32'd7, 0, 99, 33, r, dk, bc, bak);
    total++; if (dk !== 0) $display("FAIL kill33_done got cycle %0d exp none", dk); else passed++;
    total++; if (alu_result !== prev) $display("FAIL kill33_result got %h exp %h", alu_result, prev); else passed++;
    @(negedge clk);
    start = 1'b1; kill = 1'b1; alucode = C_DIV; op1 = 32'd50; op2 = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL kill_start_busy got %b exp 0", busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL kill_start_done got %b exp 0", done); else passed++;
  endtask

  task automatic test_bad_code;
    logic [31:0] prev;
    prev = alu_result;
    @(negedge clk);
    start = 1'b1; alucode = 6'd0; op1 = 32'd40; op2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL bad_code_busy got %b exp 0", busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL bad_code_done got %b exp 0", done); else passed++;
    total++; if (alu_result !== prev) $display("FAIL bad_code_result got %h exp %h", alu_result, prev); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int dk, bc;
    logic bak;
    run(C_DIV, 100, 7, 0, 99, 99, r, dk, bc, bak);
    total++; if (r !== 32'd14) $display("FAIL b2b_first_result got %h exp %h", r, 32'd14); else passed++;
    total++; if (dk !== 34) $display("FAIL b2b_first_latency got %0d exp 34", dk); else passed++;
    run(C_DIVU, 81, 9, 1, 99, 99, r, dk, bc, bak);
    total++; if (r !== 32'd9) $display("FAIL b2b_second_result got %h exp %h", r, 32'd9); else passed++;
    total++; if (dk !== 34) $display("FAIL b2b_second_latency got %0d exp 34", dk); else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_rst_mid;
    test_kill;
    test_bad_code;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
